// File: rtl/jt12_cmdp_pkg.sv
// rtl/jt12_cmdp_pkg.sv - opcodes, command field positions and FSM encoding for jt12_cmd_player
package jt12_cmdp_pkg;

   localparam logic [3:0] OP_END       = 4'd0;
   localparam logic [3:0] OP_WRITE     = 4'd1;
   localparam logic [3:0] OP_WAIT      = 4'd2;
   localparam logic [3:0] OP_WAIT_FLAG = 4'd3;
   localparam logic [3:0] OP_CHECK     = 4'd4;

   // LSB positions of the fields inside a 24-bit command word
   localparam int F_OP   = 20;
   localparam int F_CHIP = 18;
   localparam int F_A1   = 17;
   localparam int F_RSVD = 16;
   localparam int F_HI   = 8;
   localparam int F_LO   = 0;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_POLL,
      S_STROBE,
      S_BLANK,
      S_WAIT_CNT,
      S_WAIT_FLAG,
      S_DONE
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/jt12_cmdp_busmux.sv
// rtl/jt12_cmdp_busmux.sv - per-chip status select and one-hot active-low chip select
module jt12_cmdp_busmux
   import jt12_cmdp_pkg::*;
#(
   parameter int CHIPS = 1
)(
   input  logic [1:0]         chip,
   input  logic               sel,
   input  logic [8*CHIPS-1:0] din,
   output logic [7:0]         status,
   output logic [CHIPS-1:0]   cs_n
);

   always_comb begin
      status = 8'h00;
      cs_n   = '1;
      for (int k = 0; k < CHIPS; k++) begin
         if (chip == 2'(k)) begin
            status = din[8*k +: 8];
            if (sel) cs_n[k] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/jt12_cmd_player.sv
// rtl/jt12_cmd_player.sv - command sequencer issuing jt12 bus writes from a command memory
// Optional: JT12_CMDP_RANDGAP_EN randomises the BLANK length after every strobe via an LFSR.
module jt12_cmd_player
   import jt12_cmdp_pkg::*;
#(
   parameter int CMD_AW     = 12,
   parameter int CHIPS      = 1,
   parameter int WR_PULSE   = 2,
   parameter int WAIT_SHIFT = 8,
   parameter int BUSY_TO    = 4096
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [CMD_AW-1:0]  cmd_addr,
   input  logic [23:0]        cmd_data,
   output logic [CHIPS-1:0]   cs_n,
   output logic               wr_n,
   output logic [1:0]         addr,
   output logic [7:0]         dout,
   input  logic [8*CHIPS-1:0] din,
   output logic               running,
   output logic               done,
   output logic               err_timeout,
   output logic               err_illegal,
   output logic [7:0]         err_cnt
);

   localparam int PW = $clog2(BUSY_TO + 1);
   localparam int SW = $clog2(WR_PULSE + 1);
   localparam int WW = 16 + WAIT_SHIFT;

   state_t            state, state_nxt;
   logic [CMD_AW-1:0] pc, pc_nxt;
   logic [3:0]        op_q, op_nxt;
   logic [1:0]        chip_q, chip_nxt;
   logic              a1_q, a1_nxt;
   logic [7:0]        hi_q, hi_nxt, lo_q, lo_nxt;
   logic              phase, phase_nxt;
   logic [PW-1:0]     poll_cnt, poll_nxt;
   logic [SW-1:0]     st_cnt, st_nxt;
   logic [WW-1:0]     wait_cnt, wait_nxt;
   logic [1:0]        addr_nxt;
   logic [7:0]        dout_nxt;
   logic              eto_nxt, eil_nxt;
   logic [7:0]        ecnt_nxt;
   logic              advance;
   logic              strobe;
   logic              blank_last;
   logic [7:0]        status;

   logic [3:0]        d_op;
   logic [1:0]        d_chip;
   logic              d_bus_op;
   logic              d_chip_ok;
   logic              unused_rsvd;

   assign d_op        = cmd_data[F_OP +: 4];
   assign d_chip      = cmd_data[F_CHIP +: 2];
   assign d_bus_op    = (d_op == OP_WRITE) || (d_op == OP_WAIT_FLAG) || (d_op == OP_CHECK);
   assign d_chip_ok   = int'(d_chip) < CHIPS;
   assign unused_rsvd = cmd_data[F_RSVD];

   assign strobe   = (state == S_STROBE);
   assign wr_n     = ~strobe;
   assign cmd_addr = pc;
   assign running  = (state != S_IDLE) && (state != S_DONE);
   assign done     = (state == S_DONE);

   jt12_cmdp_busmux #(.CHIPS(CHIPS)) u_busmux (
      .chip   (chip_q),
      .sel    (strobe),
      .din    (din),
      .status (status),
      .cs_n   (cs_n)
   );

`ifdef JT12_CMDP_RANDGAP_EN
   logic [15:0] lfsr;
   logic [6:0]  blank_cnt;

   // Reloaded on every STROBE cycle so the value from the last one sets the gap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr      <= 16'hACE1;
         blank_cnt <= 7'd0;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (state == S_STROBE)
            blank_cnt <= 7'(lfsr[6:0] % 7'd100);
         else if (state == S_BLANK && blank_cnt != 7'd0)
            blank_cnt <= blank_cnt - 7'd1;
      end
   end

   assign blank_last = (blank_cnt == 7'd0);
`else
   assign blank_last = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= '0;
         op_q        <= OP_END;
         chip_q      <= 2'd0;
         a1_q        <= 1'b0;
         hi_q        <= 8'h00;
         lo_q        <= 8'h00;
         phase       <= 1'b0;
         poll_cnt    <= '0;
         st_cnt      <= '0;
         wait_cnt    <= '0;
         addr        <= 2'd0;
         dout        <= 8'h00;
         err_timeout <= 1'b0;
         err_illegal <= 1'b0;
         err_cnt     <= 8'h00;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         op_q        <= op_nxt;
         chip_q      <= chip_nxt;
         a1_q        <= a1_nxt;
         hi_q        <= hi_nxt;
         lo_q        <= lo_nxt;
         phase       <= phase_nxt;
         poll_cnt    <= poll_nxt;
         st_cnt      <= st_nxt;
         wait_cnt    <= wait_nxt;
         addr        <= addr_nxt;
         dout        <= dout_nxt;
         err_timeout <= eto_nxt;
         err_illegal <= eil_nxt;
         err_cnt     <= ecnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      op_nxt    = op_q;
      chip_nxt  = chip_q;
      a1_nxt    = a1_q;
      hi_nxt    = hi_q;
      lo_nxt    = lo_q;
      phase_nxt = phase;
      poll_nxt  = poll_cnt;
      st_nxt    = st_cnt;
      wait_nxt  = wait_cnt;
      addr_nxt  = addr;
      dout_nxt  = dout;
      eto_nxt   = err_timeout;
      eil_nxt   = err_illegal;
      ecnt_nxt  = err_cnt;
      advance   = 1'b0;

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt = S_FETCH;
               pc_nxt    = '0;
               eto_nxt   = 1'b0;
               eil_nxt   = 1'b0;
               ecnt_nxt  = 8'h00;
            end
         end
         S_FETCH: state_nxt = S_DECODE;
         S_DECODE: begin
            op_nxt    = d_op;
            chip_nxt  = d_chip;
            a1_nxt    = cmd_data[F_A1];
            hi_nxt    = cmd_data[F_HI +: 8];
            lo_nxt    = cmd_data[F_LO +: 8];
            phase_nxt = 1'b0;
            poll_nxt  = '0;
            if (d_op == OP_END) begin
               state_nxt = S_DONE;
            end else if (d_op == OP_WAIT) begin
               wait_nxt  = WW'(cmd_data[15:0]) << WAIT_SHIFT;
               state_nxt = S_WAIT_CNT;
            end else if (d_bus_op && d_chip_ok) begin
               state_nxt = S_POLL;
            end else begin
               eil_nxt = 1'b1;
               advance = 1'b1;
            end
         end
         S_POLL: begin
            if (status[7]) begin
               if (poll_cnt == PW'(BUSY_TO - 1)) begin
                  eto_nxt   = 1'b1;
                  state_nxt = S_DONE;
               end else begin
                  poll_nxt = poll_cnt + PW'(1);
               end
            end else begin
               case (op_q)
                  OP_WRITE: begin
                     state_nxt = S_STROBE;
                     st_nxt    = '0;
                     addr_nxt  = {a1_q, phase};
                     dout_nxt  = phase ? lo_q : hi_q;
                  end
                  OP_WAIT_FLAG: state_nxt = S_WAIT_FLAG;
                  default: begin
                     if ((status & hi_q) != lo_q) ecnt_nxt = sat_inc8(err_cnt);
                     advance = 1'b1;
                  end
               endcase
            end
         end
         S_STROBE: begin
            if (st_cnt == SW'(WR_PULSE - 1)) state_nxt = S_BLANK;
            else                             st_nxt    = st_cnt + SW'(1);
         end
         S_BLANK: begin
            if (blank_last) begin
               if (!phase) begin
                  phase_nxt = 1'b1;
                  poll_nxt  = '0;
                  state_nxt = S_POLL;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         S_WAIT_CNT: begin
            if (wait_cnt <= WW'(1)) advance  = 1'b1;
            else                    wait_nxt = wait_cnt - WW'(1);
         end
         S_WAIT_FLAG: begin
            if ((status & lo_q) != 8'h00) advance = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase

      // Running off the end of command memory counts as a malformed program.
      if (advance) begin
         if (pc == '1) begin
            eil_nxt   = 1'b1;
            state_nxt = S_DONE;
         end else begin
            pc_nxt    = pc + CMD_AW'(1);
            state_nxt = S_FETCH;
         end
      end
   end

endmodule

// File: tb/tb_jt12_cmd_player.sv
// tb/tb_jt12_cmd_player.sv - directed table-driven bench for jt12_cmd_player
module tb_jt12_cmd_player;

   localparam int CMD_AW     = 4;
   localparam int CHIPS      = 2;
   localparam int WR_PULSE   = 2;
   localparam int WAIT_SHIFT = 8;
   localparam int BUSY_TO    = 4096;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [CMD_AW-1:0]  cmd_addr;
   logic [23:0]        cmd_data;
   logic [CHIPS-1:0]   cs_n;
   logic               wr_n;
   logic [1:0]         addr;
   logic [7:0]         dout;
   logic [8*CHIPS-1:0] din = '0;
   logic               running, done, err_timeout, err_illegal;
   logic [7:0]         err_cnt;

   logic [23:0] mem [2**CMD_AW];
   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cmd_data <= mem[cmd_addr];

   jt12_cmd_player #(
      .CMD_AW(CMD_AW), .CHIPS(CHIPS), .WR_PULSE(WR_PULSE),
      .WAIT_SHIFT(WAIT_SHIFT), .BUSY_TO(BUSY_TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .dout(dout), .din(din),
      .running(running), .done(done), .err_timeout(err_timeout),
      .err_illegal(err_illegal), .err_cnt(err_cnt)
   );

   // Cycle offsets count negedges after the edge that samples start.
   typedef struct {
      logic [23:0] p0, p1, p2, p3, fill;
      int din_base, bchip, hold;
      int done_at, nstr;
      int a_cyc, a_addr, a_dout;
      int b_cyc, b_addr, b_dout;
      int cs, eto, eil, ecnt;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int k, done_k, nstr, busy_left;
      logic prev_wr;
      int s_cyc[4], s_addr[4], s_dout[4], s_cs[4], s_len[4];
      int ec[2], ea[2], ed[2];
      mem[0] = v.p0; mem[1] = v.p1; mem[2] = v.p2; mem[3] = v.p3;
      for (int i = 4; i < 2**CMD_AW; i++) mem[i] = v.fill;
      ec[0] = v.a_cyc; ea[0] = v.a_addr; ed[0] = v.a_dout;
      ec[1] = v.b_cyc; ea[1] = v.b_addr; ed[1] = v.b_dout;
      @(negedge clk);
      start = 1'b1;
      busy_left = (v.hold > 0) ? v.hold + 3 : 0;
      din = 16'(v.din_base) | ((busy_left > 0) ? (16'h0080 << (8*v.bchip)) : 16'h0000);
      if (busy_left > 0) busy_left--;
      k = 0; done_k = -1; nstr = 0; prev_wr = 1'b1;
      while (done_k < 0 && k < 6000) begin
         @(negedge clk);
         start = 1'b0;
         if (done) done_k = k;
         if (!wr_n) begin
            if (prev_wr) begin
               if (nstr < 4) begin
                  s_cyc[nstr] = k; s_addr[nstr] = int'(addr);
                  s_dout[nstr] = int'(dout); s_cs[nstr] = int'(cs_n); s_len[nstr] = 0;
               end
               nstr++;
            end
            if (nstr <= 4) s_len[nstr-1]++;
         end else if (!prev_wr && v.hold > 0) begin
            busy_left = v.hold + 1;
         end
         prev_wr = wr_n;
         din = 16'(v.din_base) | ((busy_left > 0) ? (16'h0080 << (8*v.bchip)) : 16'h0000);
         if (busy_left > 0) busy_left--;
         k++;
      end
      chk({tag, " done_at"}, done_k, v.done_at);
      chk({tag, " strobes"}, nstr, v.nstr);
      for (int i = 0; i < v.nstr && i < 2; i++) begin
         chk($sformatf("%s s%0d cyc", tag, i), s_cyc[i], ec[i]);
         chk($sformatf("%s s%0d addr", tag, i), s_addr[i], ea[i]);
         chk($sformatf("%s s%0d dout", tag, i), s_dout[i], ed[i]);
         chk($sformatf("%s s%0d cs_n", tag, i), s_cs[i], v.cs);
         chk($sformatf("%s s%0d len", tag, i), s_len[i], WR_PULSE);
      end
      chk({tag, " err_timeout"}, int'(err_timeout), v.eto);
      chk({tag, " err_illegal"}, int'(err_illegal), v.eil);
      chk({tag, " err_cnt"}, int'(err_cnt), v.ecnt);
      chk({tag, " running"}, int'(running), 0);
      chk({tag, " cs_n idle"}, int'(cs_n), 3);
      chk({tag, " wr_n idle"}, int'(wr_n), 1);
   endtask

   initial begin
      int seen;
      //            p0          p1          p2          p3     fill        din      bch hold done nstr a_cyc/addr/dout  b_cyc/addr/dout cs eto eil ecnt
      vecs[0] = '{24'h1028F0, 24'h000000, 24'h000000, 24'h0, 24'h000000, 'h0000, 0, 0,    12,  2, 3, 0, 'h28,  7, 1, 'hF0, 2, 0, 0, 0};
      vecs[1] = '{24'h1028F0, 24'h000000, 24'h000000, 24'h0, 24'h000000, 'h0000, 0, 10,   32,  2, 13, 0, 'h28, 27, 1, 'hF0, 2, 0, 0, 0};
      vecs[2] = '{24'h1028F0, 24'h000000, 24'h000000, 24'h0, 24'h000000, 'h0000, 0, 9999, 4098, 0, 0, 0, 0,    0, 0, 0,    3, 1, 0, 0};
      vecs[3] = '{24'h200003, 24'h000000, 24'h000000, 24'h0, 24'h000000, 'h0000, 0, 0,    772, 0, 0, 0, 0,    0, 0, 0,    3, 0, 0, 0};
      vecs[4] = '{24'h200000, 24'h000000, 24'h000000, 24'h0, 24'h000000, 'h0000, 0, 0,    5,   0, 0, 0, 0,    0, 0, 0,    3, 0, 0, 0};
      vecs[5] = '{24'h143071, 24'h440301, 24'h000000, 24'h0, 24'h000000, 'h0280, 1, 0,    15,  2, 3, 0, 'h30,  7, 1, 'h71, 1, 0, 0, 1};
      vecs[6] = '{24'h700000, 24'h1C1122, 24'h1255AA, 24'h0, 24'h000000, 'h0000, 0, 0,    16,  2, 7, 2, 'h55, 11, 3, 'hAA, 2, 0, 1, 0};
      vecs[7] = '{24'h300001, 24'h000000, 24'h000000, 24'h0, 24'h000000, 'h0001, 0, 0,    6,   0, 0, 0, 0,    0, 0, 0,    3, 0, 0, 0};
      vecs[8] = '{24'h40F050, 24'h000000, 24'h000000, 24'h0, 24'h000000, 'h0057, 0, 0,    5,   0, 0, 0, 0,    0, 0, 0,    3, 0, 0, 0};
      vecs[9] = '{24'h200000, 24'h200000, 24'h200000, 24'h200000, 24'h200000, 'h0000, 0, 0, 48, 0, 0, 0, 0,  0, 0, 0,    3, 0, 1, 0};
      for (int i = 0; i < 2**CMD_AW; i++) mem[i] = 24'h0;

      repeat (3) @(negedge clk);
      chk("reset cs_n", int'(cs_n), 3);
      chk("reset wr_n", int'(wr_n), 1);
      chk("reset addr", int'(addr), 0);
      chk("reset dout", int'(dout), 0);
      chk("reset cmd_addr", int'(cmd_addr), 0);
      chk("reset running", int'(running), 0);
      chk("reset done", int'(done), 0);
      chk("reset err_timeout", int'(err_timeout), 0);
      chk("reset err_illegal", int'(err_illegal), 0);
      chk("reset err_cnt", int'(err_cnt), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Reset while a strobe is on the bus, then replay from command 0.
      mem[0] = 24'h1028F0; mem[1] = 24'h000000;
      din = '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         if (!wr_n) seen = 1;
         else @(negedge clk);
      end
      chk("rst strobe seen", seen, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst wr_n", int'(wr_n), 1);
      chk("rst cs_n", int'(cs_n), 3);
      chk("rst running", int'(running), 0);
      chk("rst done", int'(done), 0);
      rst_n = 1'b1;
      run_vec(vecs[0], "replay");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
